mole_round_controller: RTL and testbench
========================================

// Module: mole_round_controller
// PURPOSE
//   Parametrised whack-a-mole round engine: pseudo-randomly lights one of
//   NUM_MOLES moles per round, detects button presses, and keeps a saturating
//   score. Fully synchronous successor to the display/player pair.
//   Sits between board buttons/LEDs and the score hex decoders.
//   The level FSM drives speed_cycles.
// PARAMETERS
//   NUM_MOLES   3            number of moles/buttons (2..16)
//   TIMER_W     28           width of the round/gap down-counter
//   GAP_CYCLES  150000000    dark cycles between rounds (>=1)
//   SCORE_W     8            score width
//   LFSR_W      8            LFSR width
//   LFSR_TAPS   8'hB8        Galois feedback mask (x^8+x^6+x^5+x^4+1)
//   LFSR_SEED   8'hA5        nonzero LFSR reset/restart value
// PORTS
//   clock         in   1          system clock
//   reset         in   1          async, active-high
//   game          in   1          1 = play; 0 = stop and clear
//   buttons       in   NUM_MOLES  synchronised, active-high button levels
//   speed_cycles  in   TIMER_W    mole-visible cycles per round; 0 treated as 1
//   moles         out  NUM_MOLES  one-hot lit mole, or all zero
//   score         out  SCORE_W    current score
//   hit_pulse     out  1          1-cycle pulse on a scored hit
//   miss_pulse    out  1          1-cycle pulse on timeout (and wrong press, see macro)
//   round_active  out  1          1 while in SHOW
// BEHAVIOUR
//   Interface: one clock (clock); reset is asynchronous and active-high.
//   Reset: moles=0, score=0, hit_pulse=0, miss_pulse=0, round_active=0.
//     State=IDLE, timer=0, lfsr=LFSR_SEED, btn_q=btn_q2=0.
//   Press detect: btn_q<=buttons; btn_q2<=btn_q; press=btn_q&~btn_q2.
//     A held button counts once.
//   Latency: buttons rise before edge k; score/pulse/moles update at edge k+1.
//   LFSR: Galois shift each cycle while state!=IDLE; reloads LFSR_SEED in IDLE.
//     An all-zero value is replaced by LFSR_SEED.
//   Mole index: idx=(lfsr*NUM_MOLES)>>LFSR_W, sampled on the GAP->SHOW edge.
//     Range is 0..NUM_MOLES-1; no divider.
//   FSM:
//     IDLE: outputs 0. On game=1, go to GAP with timer=GAP_CYCLES-1.
//     GAP: moles=0; decrement timer. At timer==0, go to SHOW.
//       On entry: moles=1<<idx, timer=max(speed_cycles,1)-1.
//     SHOW: decrement timer.
//       press[idx] -> score+1 (saturate at 2^SCORE_W-1), hit_pulse, moles=0,
//         go to GAP (timer reload).
//       timer==0 with no hit -> miss_pulse, moles=0, go to GAP.
//       Correct and wrong bits pressed together: correct wins; counts as hit only.
//       Hit on the same cycle as timer==0: hit wins; no miss_pulse.
//   Presses in IDLE/GAP are ignored. speed_cycles is sampled only on SHOW entry.
//   game=0 in any state: next edge goes to IDLE; score, moles and pulses clear.
//   Reset mid-round: immediate return to reset values.
// CONFIGURATION
//   WRONG_PRESS_PENALTY_EN defined:
//     In SHOW, a press on a non-lit button only (no press[idx]) does:
//       score-1 (floor 0), miss_pulse; mole stays lit; timer keeps running.
//     Timeout also applies score-1 (floor 0).
//   Not defined: wrong presses are ignored; timeout leaves score unchanged.
// TESTING  (NUM_MOLES=3, GAP_CYCLES=4, SCORE_W=4, speed_cycles=5)
//   1 Reset asserted mid-SHOW -> moles=0, score=0, pulses=0 with no clock edge.
//   2 game=1, no presses -> 4 cycles moles=0, then one-hot for 5 cycles,
//     then miss_pulse for 1 cycle and score=0.
//     Idx sequence is identical on every game restart.
//   3 Press lit button during SHOW -> score 0->1 and hit_pulse 2 edges later;
//     moles=0 on the same edge.
//   4 Sixteen consecutive hits -> score stops at 15; hit_pulse still fires.
//   5 Wrong button: no macro -> score stays 3; macro -> 3->2, then 0 stays 0.
//     Both buttons pressed together -> hit counted.
//   6 Button held across 3 rounds -> at most one hit.
//     game=0 -> IDLE, score=0 next edge.

Source files
------------

// File: rtl/mole_round_controller.sv
// mole_round_controller
//   Whack-a-mole round engine. Each round waits GAP_CYCLES dark cycles. It
//   then lights one pseudo-randomly chosen mole for speed_cycles cycles and
//   watches for a rising press on that mole's button. The score saturates at
//   the top of its range.
//   Optional feature: define WRONG_PRESS_PENALTY_EN to penalise presses on
//   unlit buttons and timeouts (score-1, floored at 0).
//
//   state | meaning
//   IDLE  | game stopped, score cleared, LFSR held at seed
//   GAP   | dark interval between rounds, counting down
//   SHOW  | one mole lit, waiting for a hit or a timeout

module mole_round_controller #(
  parameter int unsigned NUM_MOLES  = 3,
  parameter int unsigned TIMER_W    = 28,
  parameter int unsigned GAP_CYCLES = 150000000,
  parameter int unsigned SCORE_W    = 8,
  parameter int unsigned LFSR_W     = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 game,
  input  logic [NUM_MOLES-1:0] buttons,
  input  logic [TIMER_W-1:0]   speed_cycles,
  output logic [NUM_MOLES-1:0] moles,
  output logic [SCORE_W-1:0]   score,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic                 round_active
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  localparam int unsigned IDX_W = $clog2(NUM_MOLES);
  localparam int unsigned MUL_W = LFSR_W + $clog2(NUM_MOLES + 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
  logic [NUM_MOLES-1:0] btn_q, btn_q2;
  logic [NUM_MOLES-1:0] moles_q, moles_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;

  logic [NUM_MOLES-1:0] press;
  logic                 lit_press;
  logic                 timer_zero;
  logic [LFSR_W-1:0]    lfsr_shift;
  logic [LFSR_W-1:0]    lfsr_adv;
  logic [MUL_W-1:0]     idx_prod;
  logic [IDX_W-1:0]     idx_new;
  logic [TIMER_W-1:0]   speed_load;
  logic [SCORE_W-1:0]   score_inc;
`ifdef WRONG_PRESS_PENALTY_EN
  logic                 wrong_press;
  logic [SCORE_W-1:0]   score_dec;
`endif

  // Two-stage button history so a held button yields a single press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_q  <= '0;
      btn_q2 <= '0;
    end else begin
      btn_q  <= buttons;
      btn_q2 <= btn_q;
    end
  end

  // Press, LFSR step, mole index and reload helpers.
  always_comb begin
    press      = btn_q & ~btn_q2;
    // moles_q is the one-hot lit mole during SHOW, so this is press[idx].
    lit_press  = |(press & moles_q);
    timer_zero = (timer_q == '0);
    lfsr_shift = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    lfsr_adv   = (lfsr_shift == '0) ? LFSR_SEED : lfsr_shift;
    // Scale the LFSR value into 0..NUM_MOLES-1 with a multiply-and-shift.
    idx_prod   = (MUL_W'(lfsr_q) * MUL_W'(NUM_MOLES)) >> LFSR_W;
    idx_new    = IDX_W'(idx_prod);
    speed_load = (speed_cycles == '0) ? '0 : speed_cycles - 1'b1;
    score_inc  = (score_q == SCORE_MAX) ? SCORE_MAX : score_q + 1'b1;
`ifdef WRONG_PRESS_PENALTY_EN
    wrong_press = |(press & ~moles_q);
    score_dec   = (score_q == '0) ? '0 : score_q - 1'b1;
`endif
  end

  // State and registered datapath/outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      lfsr_q  <= LFSR_SEED;
      moles_q <= '0;
      score_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lfsr_q  <= lfsr_d;
      moles_q <= moles_d;
      score_q <= score_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state selection; game=0 wins over everything.
  always_comb begin
    state_d = state_q;
    if (!game) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_GAP;
        ST_GAP:  if (timer_zero) state_d = ST_SHOW;
        ST_SHOW: if (lit_press || timer_zero) state_d = ST_GAP;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Next values for the timer, LFSR, moles, score and pulses.
  always_comb begin
    timer_d = timer_q;
    lfsr_d  = lfsr_adv;
    moles_d = moles_q;
    score_d = score_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    if (!game) begin
      timer_d = '0;
      lfsr_d  = LFSR_SEED;
      moles_d = '0;
      score_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          lfsr_d  = LFSR_SEED;
          moles_d = '0;
          timer_d = GAP_LOAD;
        end
        ST_GAP: begin
          moles_d = '0;
          if (timer_zero) begin
            moles_d = NUM_MOLES'(1) << idx_new;
            timer_d = speed_load;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_SHOW: begin
          if (lit_press) begin
            // A correct press beats both a simultaneous wrong press and timeout.
            score_d = score_inc;
            hit_d   = 1'b1;
            moles_d = '0;
            timer_d = GAP_LOAD;
          end else if (timer_zero) begin
            miss_d  = 1'b1;
            moles_d = '0;
            timer_d = GAP_LOAD;
`ifdef WRONG_PRESS_PENALTY_EN
            score_d = score_dec;
`endif
          end else begin
            timer_d = timer_q - 1'b1;
`ifdef WRONG_PRESS_PENALTY_EN
            if (wrong_press) begin
              score_d = score_dec;
              miss_d  = 1'b1;
            end
`endif
          end
        end
        default: begin
          moles_d = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  // Drive the ports from the registered state.
  always_comb begin
    moles        = moles_q;
    score        = score_q;
    hit_pulse    = hit_q;
    miss_pulse   = miss_q;
    round_active = (state_q == ST_SHOW);
  end

endmodule

// File: tb/tb_mole_round_controller.sv
// Directed bench for mole_round_controller (NUM_MOLES=3, GAP_CYCLES=4,
// SCORE_W=4, speed_cycles=5). Expected mole indices were hand-derived from
// the LFSR seed: the first round lights mole 1, and the next round after a
// timeout lights mole 0.

module tb_mole_round_controller;

  logic       clock;
  logic       reset;
  logic       game;
  logic [2:0] buttons;
  logic [27:0] speed_cycles;
  logic [2:0] moles;
  logic [3:0] score;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       round_active;

  int checks = 0;
  int errors = 0;

  mole_round_controller #(
    .NUM_MOLES (3),
    .TIMER_W   (28),
    .GAP_CYCLES(4),
    .SCORE_W   (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .game        (game),
    .buttons     (buttons),
    .speed_cycles(speed_cycles),
    .moles       (moles),
    .score       (score),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .round_active(round_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_lit(output logic [2:0] lit);
    int n = 0;
    while (moles == 3'b000 && n < 30) begin
      tick();
      n++;
    end
    if (moles == 3'b000) check_val("wait_lit_timeout", 0, 1);
    lit = moles;
  endtask

  task automatic do_hit(input int exp_score);
    logic [2:0] b;
    wait_lit(b);
    buttons = b;
    tick();
    check_val("hit_still_lit", moles, b);
    tick();
    check_val("hit_pulse", hit_pulse, 1);
    check_val("hit_moles_off", moles, 0);
    check_val("hit_score", score, exp_score);
    buttons = 3'b000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] b;
    logic [2:0] w;
    int exp_score;
    int hits;

    reset = 1'b1;
    game = 1'b0;
    buttons = 3'b000;
    speed_cycles = 28'd5;
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_moles", moles, 0);
    check_val("rst_score", score, 0);
    check_val("rst_hit", hit_pulse, 0);
    check_val("rst_miss", miss_pulse, 0);
    check_val("rst_active", round_active, 0);
    reset = 1'b0;
    tick();
    tick();

    // Timeout round with no presses.
    game = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("gap_dark", moles, 0);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("show_idx0", moles, 3'b010);
      check_val("show_active", round_active, 1);
    end
    tick();
    check_val("timeout_miss", miss_pulse, 1);
    check_val("timeout_moles", moles, 0);
    check_val("timeout_score", score, 0);
    check_val("timeout_active", round_active, 0);
    tick();
    check_val("miss_one_cycle", miss_pulse, 0);
    tick();
    tick();
    check_val("gap2_dark", moles, 0);
    tick();
    check_val("show_idx1", moles, 3'b001);

    // Stop, then restart: the index sequence repeats.
    game = 1'b0;
    tick();
    check_val("stop_active", round_active, 0);
    check_val("stop_moles", moles, 0);
    game = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("restart_dark", moles, 0);
    end
    tick();
    check_val("restart_idx0", moles, 3'b010);

    // Hits with latency check.
    do_hit(1);
    do_hit(2);
    do_hit(3);

    // Wrong button, then correct+wrong together on the timeout cycle.
    wait_lit(b);
    w = (b == 3'b001) ? 3'b010 : 3'b001;
    buttons = w;
    tick();
    tick();
`ifdef WRONG_PRESS_PENALTY_EN
    check_val("wrong_score", score, 2);
    check_val("wrong_miss", miss_pulse, 1);
    exp_score = 3;
`else
    check_val("wrong_score", score, 3);
    check_val("wrong_miss", miss_pulse, 0);
    exp_score = 4;
`endif
    check_val("wrong_hit", hit_pulse, 0);
    check_val("wrong_still_lit", moles, b);
    buttons = 3'b000;
    tick();
    buttons = b | w;
    tick();
    tick();
    check_val("both_hit", hit_pulse, 1);
    check_val("both_no_miss", miss_pulse, 0);
    check_val("both_score", score, exp_score);
    check_val("both_moles_off", moles, 0);
    buttons = 3'b000;

    // Saturation.
    for (int i = 0; i < 14; i++) begin
      exp_score = (exp_score < 15) ? exp_score + 1 : 15;
      do_hit(exp_score);
    end
    check_val("sat_score", score, 15);

    // Reset mid-SHOW acts without a clock edge.
    wait_lit(b);
    reset = 1'b1;
    #1;
    check_val("midrst_moles", moles, 0);
    check_val("midrst_score", score, 0);
    check_val("midrst_hit", hit_pulse, 0);
    check_val("midrst_miss", miss_pulse, 0);
    check_val("midrst_active", round_active, 0);
    #2;
    reset = 1'b0;
    tick();

`ifdef WRONG_PRESS_PENALTY_EN
    wait_lit(b);
    w = (b == 3'b001) ? 3'b010 : 3'b001;
    buttons = w;
    tick();
    tick();
    check_val("floor_score", score, 0);
    check_val("floor_miss", miss_pulse, 1);
    buttons = 3'b000;
    tick();
`endif

    // Held button across several rounds scores once.
    wait_lit(b);
    buttons = b;
    hits = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (hit_pulse) hits++;
    end
    check_val("held_hits", hits, 1);
`ifndef WRONG_PRESS_PENALTY_EN
    check_val("held_score", score, 1);
`endif
    buttons = 3'b000;

    game = 1'b0;
    tick();
    check_val("end_score", score, 0);
    check_val("end_moles", moles, 0);
    check_val("end_active", round_active, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
